// File: rtl/rbus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rbus_pkg
//  Description : Shared constants and types for the rbus packet transmitter:
//                word width, header bit positions and the tx FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package rbus_pkg;

  localparam int RBUS_DW       = 72;
  localparam int HDR_PRIO_BIT  = 71;
  localparam int HDR_SHORT_BIT = 70;

  // Transmit sequencer: header cycle, body cycles, or nothing on the bus
  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_SEND_HDR  = 2'd1,
    TX_SEND_BODY = 2'd2
  } tx_state_t;

endpackage : rbus_pkg
`default_nettype wire

// File: rtl/rbus_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rbus_tx_fifo
//  Description : Single-clock word FIFO with show-ahead read port. The head
//                word is visible combinationally so the transmitter can
//                inspect the next header before committing to a launch.
//  Revision    : 1.0 - initial release
// ============================================================================
module rbus_tx_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 73,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Overflow/underflow are blocked here so a misbehaving caller cannot corrupt pointers
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : rbus_tx_fifo
`default_nettype wire

// File: rtl/rbus_pkt_tx.sv
`default_nettype none
// ============================================================================
//  Module      : rbus_pkt_tx
//  Description : Rbus packet source. Frames locally written packets into a
//                word FIFO, launches a complete packet only when downstream
//                credit for its lane and size is present, then streams it
//                without gaps. Framing/overflow errors raise sticky ff_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module rbus_pkt_tx
  import rbus_pkg::*;
#(
  parameter int FIFO_DEPTH = 32,
  parameter int LONG_LEN   = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_stb,
  input  logic               i_sof,
  input  logic [RBUS_DW-1:0] i_data,
  output logic               i_rdy,
  output logic               o_stb,
  output logic               o_sof,
  output logic [RBUS_DW-1:0] o_data,
  input  logic [1:0]         o_rdy,
  input  logic [1:0]         o_rdyE,
  output logic               ff_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int LW = $clog2(LONG_LEN + 1);
  localparam logic [LW-1:0] LAST_BODY = LW'(LONG_LEN - 1);

  // FIFO interface
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [RBUS_DW:0]   head_word;
  logic               head_sof;
  logic [RBUS_DW-1:0] head_data;
  logic               fifo_rd;
  logic               rd_real;

  // Write framing
  logic               in_pkt;
  logic [LW-1:0]      words_left;
  logic               wr_ok;
  logic               wr_err;
  logic               wr_done;

  // Packet bookkeeping and transmit sequencer
  logic [CW-1:0]      pkt_cnt;
  logic [CW-1:0]      count_next;
  tx_state_t          state;
  logic               cur_short;
  logic [LW-1:0]      body_cnt;
  logic               head_lane;
  logic               head_short;
  logic               credit;
  logic               tx_free;
  logic               launch;
  logic               body_rd;

  rbus_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RBUS_DW + 1)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok),
    .wr_data ({i_sof, i_data}),
    .rd_en   (fifo_rd),
    .rd_data (head_word),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head_sof   = head_word[RBUS_DW];
  assign head_data  = head_word[RBUS_DW-1:0];
  assign head_lane  = head_data[HDR_PRIO_BIT];
  assign head_short = head_data[HDR_SHORT_BIT];

  // A word is accepted only if there is room and its sof matches the framing position;
  // anything else is dropped and flagged, leaving the framing position untouched.
  assign wr_ok   = i_stb & ~fifo_full & (i_sof != in_pkt);
  assign wr_err  = i_stb & (fifo_full | (i_sof == in_pkt));
  assign wr_done = wr_ok & (in_pkt ? (words_left == LW'(1)) : i_data[HDR_SHORT_BIT]);

  // Credit is lane-specific, and short packets use the separate short-credit lane
  assign credit  = head_short ? o_rdyE[head_lane] : o_rdy[head_lane];

  // The sequencer may start a new packet when idle or while presenting the final word
  // of the current one, which is what makes back-to-back packets gap-free.
  assign tx_free = (state == TX_IDLE) |
                   ((state == TX_SEND_HDR) & cur_short) |
                   ((state == TX_SEND_BODY) & (body_cnt == LAST_BODY));
  assign launch  = tx_free & (pkt_cnt != '0) & credit;
  assign body_rd = ((state == TX_SEND_HDR) & ~cur_short) |
                   ((state == TX_SEND_BODY) & (body_cnt != LAST_BODY));
  assign fifo_rd = launch | body_rd;
  assign rd_real = fifo_rd & ~fifo_empty;

  // Occupancy after this cycle's read/write, so i_rdy reflects the state it will describe
  always_comb begin
    count_next = fifo_count;
    case ({wr_ok, rd_real})
      2'b10:   count_next = fifo_count + CW'(1);
      2'b01:   count_next = fifo_count - CW'(1);
      default: count_next = fifo_count;
    endcase
  end

  // Write framing: tracks whether we are inside a long packet and how many words remain
  always_ff @(posedge clk) begin
    if (rst) begin
      in_pkt     <= 1'b0;
      words_left <= '0;
    end else if (wr_ok) begin
      if (!in_pkt) begin
        if (!i_data[HDR_SHORT_BIT]) begin
          in_pkt     <= 1'b1;
          words_left <= LW'(LONG_LEN - 1);
        end
      end else begin
        words_left <= words_left - LW'(1);
        if (words_left == LW'(1)) in_pkt <= 1'b0;
      end
    end
  end

  // Complete packets resident in the FIFO; completion and launch in one cycle cancel
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else begin
      case ({wr_done, launch})
        2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
        2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // Transmit sequencer with registered bus outputs; bus is all-zero whenever idle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= TX_IDLE;
      cur_short <= 1'b0;
      body_cnt  <= '0;
      o_stb     <= 1'b0;
      o_sof     <= 1'b0;
      o_data    <= '0;
    end else if (launch) begin
      state     <= TX_SEND_HDR;
      cur_short <= head_short;
      body_cnt  <= '0;
      o_stb     <= 1'b1;
      o_sof     <= head_sof;
      o_data    <= head_data;
    end else if (body_rd) begin
      state     <= TX_SEND_BODY;
      body_cnt  <= body_cnt + LW'(1);
      o_stb     <= 1'b1;
      o_sof     <= head_sof;
      o_data    <= head_data;
    end else begin
      state     <= TX_IDLE;
      body_cnt  <= '0;
      o_stb     <= 1'b0;
      o_sof     <= 1'b0;
      o_data    <= '0;
    end
  end

  // Sticky error flag and writer back-pressure; i_rdy held low during reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ff_err <= 1'b0;
      i_rdy  <= 1'b0;
    end else begin
      if (wr_err) ff_err <= 1'b1;
      i_rdy <= ((CW'(FIFO_DEPTH) - count_next) >= CW'(LONG_LEN));
    end
  end

endmodule : rbus_pkt_tx
`default_nettype wire

// File: tb/tb_rbus_pkt_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rbus_pkt_tx
//  Description : Directed plus randomized bench for rbus_pkt_tx. Expected
//                output words are queued as packets are written; every bus
//                cycle is checked against the queue and the packet rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rbus_pkt_tx;

  localparam int LONG_LEN   = 9;
  localparam int FIFO_DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_stb;
  logic        i_sof;
  logic [71:0] i_data;
  logic        i_rdy;
  logic        o_stb;
  logic        o_sof;
  logic [71:0] o_data;
  logic [1:0]  o_rdy;
  logic [1:0]  o_rdyE;
  logic        ff_err;

  always #5 clk = ~clk;

  rbus_pkt_tx #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .LONG_LEN   (LONG_LEN)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_stb  (i_stb),
    .i_sof  (i_sof),
    .i_data (i_data),
    .i_rdy  (i_rdy),
    .o_stb  (o_stb),
    .o_sof  (o_sof),
    .o_data (o_data),
    .o_rdy  (o_rdy),
    .o_rdyE (o_rdyE),
    .ff_err (ff_err)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          stb_total;
  int          first_stb_cyc;
  int          last_stb_cyc;
  int          body_left = 0;
  int          c_mark;
  logic [72:0] exp_q [$];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chkw(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [71:0] rnd_word();
    logic [71:0] d;
    d[31:0]  = $urandom();
    d[63:32] = $urandom();
    d[71:64] = 8'($urandom());
    return d;
  endfunction

  // One clock; then check the bus word against the expected stream and packet rules
  task automatic tick();
    logic [1:0]  cr;
    logic [1:0]  cre;
    logic        was_rst;
    logic [72:0] e;
    logic        ln;
    cr      = o_rdy;
    cre     = o_rdyE;
    was_rst = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (was_rst) begin
      chk1("reset_stb", o_stb, 1'b0);
      body_left = 0;
      exp_q.delete();
    end else if (o_stb) begin
      stb_total++;
      if (first_stb_cyc == 0) first_stb_cyc = cyc;
      last_stb_cyc = cyc;
      chk1("sof_position", o_sof, (body_left == 0));
      if (exp_q.size() == 0) begin
        chk1("unexpected_stb", o_stb, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chkw("word", {o_sof, o_data}, e);
      end
      if (o_sof) begin
        ln = o_data[71];
        chk1("hdr_credit", o_data[70] ? cre[ln] : cr[ln], 1'b1);
        body_left = o_data[70] ? 0 : LONG_LEN - 1;
      end else if (body_left > 0) begin
        body_left--;
      end
    end else begin
      chk1("body_gap", o_stb, (body_left != 0));
      chkw("idle_zero", {o_sof, o_data}, 73'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic rtick();
    o_rdy  = 2'($urandom_range(0, 3));
    o_rdyE = 2'($urandom_range(0, 3));
    tick();
  endtask

  task automatic clear_stats();
    stb_total     = 0;
    first_stb_cyc = 0;
    last_stb_cyc  = 0;
  endtask

  // Drive one word for one cycle; push it as expected output when it is legal
  task automatic wr(input logic sof, input logic [71:0] d, input bit push);
    i_stb  = 1'b1;
    i_sof  = sof;
    i_data = d;
    if (push) exp_q.push_back({sof, d});
    tick();
    i_stb  = 1'b0;
    i_sof  = 1'b0;
    i_data = '0;
  endtask

  task automatic wr_pkt(input logic lane, input logic short_p, input bit rnd_cr);
    logic [71:0] h;
    h     = rnd_word();
    h[71] = lane;
    h[70] = short_p;
    if (rnd_cr) begin
      o_rdy  = 2'($urandom_range(0, 3));
      o_rdyE = 2'($urandom_range(0, 3));
    end
    wr(1'b1, h, 1'b1);
    if (!short_p) begin
      for (int k = 0; k < LONG_LEN - 1; k++) begin
        if (rnd_cr) begin
          o_rdy  = 2'($urandom_range(0, 3));
          o_rdyE = 2'($urandom_range(0, 3));
        end
        wr(1'b0, rnd_word(), 1'b1);
      end
    end
  endtask

  initial begin
    logic [71:0] d;
    rst = 1'b1; i_stb = 1'b0; i_sof = 1'b0; i_data = '0;
    o_rdy = 2'b00; o_rdyE = 2'b00;
    clear_stats();

    // Reset state
    idle(2);
    chk1("rst_ff_err", ff_err, 1'b0);
    chk1("rst_i_rdy", i_rdy, 1'b0);
    rst = 1'b0;
    tick();
    chk1("post_rst_i_rdy", i_rdy, 1'b1);

    // 1: long packet on lane 0 with credit held -> header two cycles after last write
    clear_stats();
    o_rdy = 2'b01;
    d = rnd_word(); d[71] = 1'b0; d[70] = 1'b0;
    wr(1'b1, d, 1'b1);
    for (int k = 0; k < LONG_LEN - 2; k++) wr(1'b0, rnd_word(), 1'b1);
    c_mark = cyc;
    wr(1'b0, rnd_word(), 1'b1);
    idle(14);
    chki("t1_hdr_latency", first_stb_cyc, c_mark + 2);
    chki("t1_stb_count", stb_total, LONG_LEN);
    chki("t1_contiguous", last_stb_cyc - first_stb_cyc, LONG_LEN - 1);

    // 2: short packet on lane 1 waits for short credit on lane 1
    clear_stats();
    o_rdy = 2'b00; o_rdyE = 2'b00;
    d = rnd_word(); d[71] = 1'b1; d[70] = 1'b1;
    wr(1'b1, d, 1'b1);
    idle(20);
    chki("t2_no_stb_wo_credit", stb_total, 0);
    o_rdyE = 2'b10;
    c_mark = cyc;
    tick();
    o_rdyE = 2'b00;
    idle(4);
    chki("t2_hdr_after_credit", first_stb_cyc, c_mark + 1);
    chki("t2_stb_count", stb_total, 1);

    // 3: three long packets queued, then released back-to-back
    clear_stats();
    for (int p = 0; p < 3; p++) begin
      chk1("t3_i_rdy_before_pkt", i_rdy, 1'b1);
      wr_pkt(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    chk1("t3_i_rdy_low_when_filling", i_rdy, 1'b0);
    idle(3);
    chki("t3_held_without_credit", stb_total, 0);
    o_rdy = 2'b11;
    idle(35);
    chki("t3_stb_count", stb_total, 3 * LONG_LEN);
    chki("t3_contiguous", last_stb_cyc - first_stb_cyc, 3 * LONG_LEN - 1);
    chk1("t3_i_rdy_after_drain", i_rdy, 1'b1);

    // 4: overflow with 33 writes and no reads, then reset recovers
    clear_stats();
    o_rdy = 2'b00; o_rdyE = 2'b00;
    for (int w = 0; w < FIFO_DEPTH + 1; w++) begin
      d = rnd_word(); d[70] = 1'b0;
      wr((w % LONG_LEN) == 0, d, 1'b0);
      if (w == FIFO_DEPTH - 1) begin
        chk1("t4_no_err_when_just_full", ff_err, 1'b0);
        chk1("t4_i_rdy_full", i_rdy, 1'b0);
      end
    end
    chk1("t4_ff_err_overflow", ff_err, 1'b1);
    chk1("t4_i_rdy_after_overflow", i_rdy, 1'b0);
    idle(3);
    chki("t4_no_output", stb_total, 0);
    rst = 1'b1;
    tick();
    chk1("t4_rst_ff_err", ff_err, 1'b0);
    chk1("t4_rst_i_rdy", i_rdy, 1'b0);
    rst = 1'b0;
    tick();
    chk1("t4_i_rdy_after_rst", i_rdy, 1'b1);
    o_rdy = 2'b11; o_rdyE = 2'b11;
    idle(5);
    chki("t4_fifo_emptied", stb_total, 0);
    wr_pkt(1'b0, 1'b1, 1'b0);
    idle(4);
    chki("t4_fresh_pkt", stb_total, 1);

    // 5: framing errors are dropped and the stream stays aligned
    clear_stats();
    d = rnd_word(); d[71] = 1'b1; d[70] = 1'b0;
    wr(1'b1, d, 1'b1);
    for (int k = 0; k < 3; k++) wr(1'b0, rnd_word(), 1'b1);
    chk1("t5_no_err_yet", ff_err, 1'b0);
    wr(1'b1, rnd_word(), 1'b0);
    chk1("t5_err_sof_mid_pkt", ff_err, 1'b1);
    for (int k = 0; k < LONG_LEN - 4; k++) wr(1'b0, rnd_word(), 1'b1);
    wr(1'b0, rnd_word(), 1'b0);
    wr_pkt(1'b0, 1'b1, 1'b0);
    idle(20);
    chki("t5_stb_count", stb_total, LONG_LEN + 1);
    chki("t5_queue_empty", exp_q.size(), 0);
    chk1("t5_err_sticky", ff_err, 1'b1);

    // 6: reset in the middle of an outgoing long packet truncates it
    clear_stats();
    o_rdy = 2'b01; o_rdyE = 2'b00;
    wr_pkt(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 40 && stb_total < 5; k++) tick();
    chki("t6_reached_word4", stb_total, 5);
    rst = 1'b1;
    tick();
    chk1("t6_rst_ff_err", ff_err, 1'b0);
    chk1("t6_rst_i_rdy", i_rdy, 1'b0);
    rst = 1'b0;
    tick();
    chk1("t6_i_rdy_after_rst", i_rdy, 1'b1);
    idle(12);
    chki("t6_no_tail_words", stb_total, 5);

    // Randomized traffic: random sizes, lanes and credit patterns
    clear_stats();
    for (int p = 0; p < 10; p++) begin
      for (int k = 0; k < 60 && !i_rdy; k++) rtick();
      chk1("rnd_i_rdy", i_rdy, 1'b1);
      wr_pkt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      for (int k = 0; k < int'($urandom_range(0, 4)); k++) rtick();
    end
    o_rdy = 2'b11; o_rdyE = 2'b11;
    idle(100);
    chki("rnd_drained", exp_q.size(), 0);
    chk1("rnd_no_err", ff_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_rbus_pkt_tx
`default_nettype wire
